// File: rtl/rv64_div_pkg.sv
// ---------------------------------------------------------------------------
// rv64_div_pkg
// Shared definitions for the RV64M divide controller:
//   - opcode / funct3 constants for the eight divide-class instructions
//   - FSM state enumeration used by div_ctrl
//   - INT64_MIN / INT32_MIN overflow constants
//   - div_decode(): legality, W-form, signedness and remainder flags
//   - sext32(): sign-extend a 32-bit result to 64 bits
// ---------------------------------------------------------------------------
package rv64_div_pkg;

   localparam logic [6:0] OPC_OP   = 7'b0110011;
   localparam logic [6:0] OPC_OP32 = 7'b0111011;

   localparam logic [9:0] OP_DIV   = {OPC_OP,   3'b100};
   localparam logic [9:0] OP_DIVU  = {OPC_OP,   3'b101};
   localparam logic [9:0] OP_REM   = {OPC_OP,   3'b110};
   localparam logic [9:0] OP_REMU  = {OPC_OP,   3'b111};
   localparam logic [9:0] OP_DIVW  = {OPC_OP32, 3'b100};
   localparam logic [9:0] OP_DIVUW = {OPC_OP32, 3'b101};
   localparam logic [9:0] OP_REMW  = {OPC_OP32, 3'b110};
   localparam logic [9:0] OP_REMUW = {OPC_OP32, 3'b111};

   localparam logic [63:0] INT64_MIN = 64'h8000_0000_0000_0000;
   localparam logic [31:0] INT32_MIN = 32'h8000_0000;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_BUSY   = 3'd2,
      ST_RESP   = 3'd3,
      ST_DRAIN  = 3'd4
   } div_state_t;

   typedef struct packed {
      logic legal;
      logic is_w;
      logic is_signed;
      logic is_rem;
   } div_dec_t;

   // funct3[2] selects the M-extension divide group; funct3[0]=0 is signed,
   // funct3[1]=1 selects the remainder.
   function automatic div_dec_t div_decode(input logic [9:0] op);
      div_dec_t d;
      d.is_w      = (op[9:3] == OPC_OP32);
      d.legal     = ((op[9:3] == OPC_OP) || (op[9:3] == OPC_OP32)) && op[2];
      d.is_signed = ~op[0];
      d.is_rem    = op[1];
      return d;
   endfunction

   function automatic logic [63:0] sext32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

endpackage

// File: rtl/div_special_case.sv
// ---------------------------------------------------------------------------
// div_special_case
// Combinational detection of the divide cases that need no iteration:
// divide-by-zero and signed overflow. W forms look at the low 32 bits only.
// Ports:
//   i_op   [9:0]  {opcode, funct3}
//   i_rs1  [63:0] dividend
//   i_rs2  [63:0] divisor
//   o_hit         operation resolves here
//   o_data [63:0] architectural result when o_hit is set
// ---------------------------------------------------------------------------
module div_special_case
   import rv64_div_pkg::*;
(
   input  logic [9:0]  i_op,
   input  logic [63:0] i_rs1,
   input  logic [63:0] i_rs2,
   output logic        o_hit,
   output logic [63:0] o_data
);

   div_dec_t w_dec;
   logic     w_div0;
   logic     w_ovf;

   // classify the operands and pick the fixed architectural result
   always_comb begin
      w_dec  = div_decode(i_op);
      w_div0 = w_dec.is_w ? (i_rs2[31:0] == 32'd0) : (i_rs2 == 64'd0);
      w_ovf  = w_dec.is_signed &&
               (w_dec.is_w ? ((i_rs1[31:0] == INT32_MIN) && (i_rs2[31:0] == 32'hFFFF_FFFF))
                           : ((i_rs1 == INT64_MIN) && (i_rs2 == {64{1'b1}})));
      o_hit  = w_dec.legal && (w_div0 || w_ovf);
      if (w_div0) begin
         if (w_dec.is_rem) begin
            o_data = w_dec.is_w ? sext32(i_rs1[31:0]) : i_rs1;
         end else begin
            o_data = {64{1'b1}};
         end
      end else if (w_ovf) begin
         if (w_dec.is_rem) begin
            o_data = 64'd0;
         end else begin
            o_data = w_dec.is_w ? sext32(INT32_MIN) : INT64_MIN;
         end
      end else begin
         o_data = 64'd0;
      end
   end

endmodule

// File: rtl/div_ctrl.sv
// ---------------------------------------------------------------------------
// div_ctrl
// EX-stage controller wrapped around the 64-bit iterative divider. Accepts a
// decoded divide-class instruction, stalls the pipeline while it runs,
// resolves divide-by-zero / overflow in one cycle, and hands the result to
// writeback with a valid/ready handshake. Flushes mid-operation drain the
// divider (it cannot abort) and never produce a writeback.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ex_valid_i, ex_inst_op_f3, ex_rs1_data, ex_rs2_data, ex_rd_addr  from EX
//   flush_i                  kill the in-flight instruction
//   stall_o                  hold IF/ID/EX
//   div_dividend, div_divisor, div_op, div_start   to divider
//   div_result, div_done     from divider
//   wb_valid_o, wb_rd_addr, wb_data, wb_ready_i    writeback handshake
// ---------------------------------------------------------------------------
module div_ctrl
   import rv64_div_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid_i,
   input  logic [9:0]  ex_inst_op_f3,
   input  logic [63:0] ex_rs1_data,
   input  logic [63:0] ex_rs2_data,
   input  logic [4:0]  ex_rd_addr,
   input  logic        flush_i,
   output logic        stall_o,
   output logic [63:0] div_dividend,
   output logic [63:0] div_divisor,
   output logic [9:0]  div_op,
   output logic        div_start,
   input  logic [63:0] div_result,
   input  logic        div_done,
   output logic        wb_valid_o,
   output logic [4:0]  wb_rd_addr,
   output logic [63:0] wb_data,
   input  logic        wb_ready_i
);

   div_state_t  r_state;
   div_state_t  w_next_state;

   logic [63:0] r_dividend;
   logic [63:0] r_divisor;
   logic [9:0]  r_op;
   logic [4:0]  r_rd;
   logic [63:0] r_wb_data;

   logic        w_accept;
   logic        w_sc_hit;
   logic [63:0] w_sc_data;
   div_dec_t    w_ex_dec;

   div_special_case u_special (
      .i_op   (ex_inst_op_f3),
      .i_rs1  (ex_rs1_data),
      .i_rs2  (ex_rs2_data),
      .o_hit  (w_sc_hit),
      .o_data (w_sc_data)
   );

   // accept qualification; reset gating keeps every output low during reset
   always_comb begin
      w_ex_dec = div_decode(ex_inst_op_f3);
      w_accept = (r_state == ST_IDLE) && ex_valid_i && w_ex_dec.legal && !flush_i && !rst;
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_next_state = w_sc_hit ? ST_RESP : ST_LAUNCH;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_LAUNCH: begin
            w_next_state = flush_i ? ST_DRAIN : ST_BUSY;
         end
         ST_BUSY: begin
            // a flush coinciding with div_done has nothing left to drain
            if (flush_i) begin
               w_next_state = div_done ? ST_IDLE : ST_DRAIN;
            end else if (div_done) begin
               w_next_state = ST_RESP;
            end else begin
               w_next_state = ST_BUSY;
            end
         end
         ST_RESP: begin
            if (flush_i || wb_ready_i) begin
               w_next_state = ST_IDLE;
            end else begin
               w_next_state = ST_RESP;
            end
         end
         ST_DRAIN: begin
            w_next_state = div_done ? ST_IDLE : ST_DRAIN;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // outputs decoded from the registered state (stall also sees the accept)
   always_comb begin
      stall_o    = 1'b0;
      wb_valid_o = 1'b0;
      div_start  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            stall_o = w_accept;
         end
         ST_LAUNCH: begin
            stall_o   = 1'b1;
            div_start = 1'b1;
         end
         ST_BUSY: begin
            stall_o = 1'b1;
         end
         ST_RESP: begin
            stall_o    = !wb_ready_i;
            wb_valid_o = 1'b1;
         end
         ST_DRAIN: begin
            stall_o = 1'b1;
         end
         default: begin
            stall_o = 1'b0;
         end
      endcase
   end

   // operand latch on accept, result capture from fast path or divider
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dividend <= 64'd0;
         r_divisor  <= 64'd0;
         r_op       <= 10'd0;
         r_rd       <= 5'd0;
         r_wb_data  <= 64'd0;
      end else if (w_accept) begin
         r_dividend <= ex_rs1_data;
         r_divisor  <= ex_rs2_data;
         r_op       <= ex_inst_op_f3;
         r_rd       <= ex_rd_addr;
         if (w_sc_hit) begin
            r_wb_data <= w_sc_data;
         end else begin
            r_wb_data <= r_wb_data;
         end
      end else if ((r_state == ST_BUSY) && div_done && !flush_i) begin
         r_wb_data <= div_result;
      end else begin
         r_wb_data <= r_wb_data;
      end
   end

   assign div_dividend = r_dividend;
   assign div_divisor  = r_divisor;
   assign div_op       = r_op;
   assign wb_rd_addr   = r_rd;
   assign wb_data      = r_wb_data;

endmodule

// File: tb/tb_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_ctrl
// Self-checking bench for div_ctrl with a timing-accurate divider stand-in
// (start -> done after 67 cycles) whose result comes from an arithmetic
// reference of the RISC-V divide rules.
// ---------------------------------------------------------------------------
module tb_div_ctrl;

   localparam logic [9:0] T_DIV   = 10'b0110011_100;
   localparam logic [9:0] T_DIVU  = 10'b0110011_101;
   localparam logic [9:0] T_REM   = 10'b0110011_110;
   localparam logic [9:0] T_REMU  = 10'b0110011_111;
   localparam logic [9:0] T_DIVW  = 10'b0111011_100;
   localparam logic [9:0] T_DIVUW = 10'b0111011_101;
   localparam logic [9:0] T_REMW  = 10'b0111011_110;
   localparam logic [9:0] T_REMUW = 10'b0111011_111;
   localparam logic [63:0] MIN64  = 64'h8000_0000_0000_0000;
   localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid_i;
   logic [9:0]  ex_inst_op_f3;
   logic [63:0] ex_rs1_data;
   logic [63:0] ex_rs2_data;
   logic [4:0]  ex_rd_addr;
   logic        flush_i;
   logic        stall_o;
   logic [63:0] div_dividend;
   logic [63:0] div_divisor;
   logic [9:0]  div_op;
   logic        div_start;
   logic [63:0] div_result;
   logic        div_done;
   logic        wb_valid_o;
   logic [4:0]  wb_rd_addr;
   logic [63:0] wb_data;
   logic        wb_ready_i;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   div_ctrl dut (
      .clk(clk), .rst(rst), .ex_valid_i(ex_valid_i), .ex_inst_op_f3(ex_inst_op_f3),
      .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_rd_addr(ex_rd_addr),
      .flush_i(flush_i), .stall_o(stall_o), .div_dividend(div_dividend),
      .div_divisor(div_divisor), .div_op(div_op), .div_start(div_start),
      .div_result(div_result), .div_done(div_done), .wb_valid_o(wb_valid_o),
      .wb_rd_addr(wb_rd_addr), .wb_data(wb_data), .wb_ready_i(wb_ready_i)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // RISC-V M-extension result rules expressed with plain arithmetic
   function automatic logic [63:0] ref_result(input logic [9:0] op, input logic [63:0] a, input logic [63:0] b);
      logic        w, sg, rm;
      logic [31:0] a32, b32, q32, r32;
      logic [63:0] q, r;
      w  = (op[9:3] == 7'b0111011);
      sg = ~op[0];
      rm = op[1];
      if (w) begin
         a32 = a[31:0];
         b32 = b[31:0];
         if (b32 == 32'd0) begin
            q32 = 32'hFFFF_FFFF; r32 = a32;
         end else if (sg && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
            q32 = a32; r32 = 32'd0;
         end else if (sg) begin
            q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32);
         end else begin
            q32 = a32 / b32; r32 = a32 % b32;
         end
         q = {{32{q32[31]}}, q32};
         r = {{32{r32[31]}}, r32};
      end else begin
         if (b == 64'd0) begin
            q = ONES; r = a;
         end else if (sg && a == MIN64 && b == ONES) begin
            q = a; r = 64'd0;
         end else if (sg) begin
            q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
         end else begin
            q = a / b; r = a % b;
         end
      end
      return rm ? r : q;
   endfunction

   function automatic bit ref_fast(input logic [9:0] op, input logic [63:0] a, input logic [63:0] b);
      if (op[9:3] == 7'b0111011)
         return (b[31:0] == 32'd0) || (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
      else
         return (b == 64'd0) || (!op[0] && a == MIN64 && b == ONES);
   endfunction

   // divider stand-in: counter 1 the cycle after start, done at 67
   logic [6:0] dv_cnt;
   always @(posedge clk) begin
      if (rst) dv_cnt <= 7'd0;
      else if (div_start) dv_cnt <= 7'd1;
      else if (dv_cnt == 7'd67) dv_cnt <= 7'd0;
      else if (dv_cnt != 7'd0) dv_cnt <= dv_cnt + 7'd1;
   end
   assign div_done   = (dv_cnt == 7'd67);
   assign div_result = ref_result(div_op, div_dividend, div_divisor);

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // operand hold from launch to done; no restart while the divider runs
   int done_cyc = -100;
   int start_cyc = -100;
   initial begin
      logic [63:0] m_a, m_b;
      logic [9:0]  m_op;
      logic        m_arm, m_bad;
      m_arm = 1'b0; m_bad = 1'b0; m_a = 64'd0; m_b = 64'd0; m_op = 10'd0;
      forever begin
         @(negedge clk);
         if (rst) begin
            m_arm = 1'b0;
         end else begin
            if (div_done) done_cyc = cyc;
            if (m_arm) begin
               if (div_dividend !== m_a || div_divisor !== m_b || div_op !== m_op) m_bad = 1'b1;
               if (div_done) begin
                  chk("operand_hold", {63'd0, m_bad}, 64'd0);
                  m_arm = 1'b0;
               end
            end
            if (div_start) begin
               chk("start_while_busy", {63'd0, m_arm}, 64'd0);
               m_arm = 1'b1; m_bad = 1'b0;
               m_a = div_dividend; m_b = div_divisor; m_op = div_op;
               start_cyc = cyc;
            end
         end
      end
   end

   // one full transaction starting in the current (IDLE) cycle
   task automatic issue(input string nm, input logic [9:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] rd, input int hold, input logic [63:0] exp_d, input bit exp_fast);
      int n, starts, first_start;
      logic [63:0] d0;
      ex_valid_i = 1'b1; ex_inst_op_f3 = op; ex_rs1_data = a; ex_rs2_data = b; ex_rd_addr = rd;
      wb_ready_i = (hold == 0);
      #1;
      chk({nm, "/accept_stall"}, stall_o, 64'd1);
      @(posedge clk); #1;
      ex_valid_i = 1'b0;
      ex_rs1_data = {$urandom, $urandom};
      ex_rs2_data = {$urandom, $urandom};
      n = 1; starts = 0; first_start = 0;
      while (n < 150 && !wb_valid_o) begin
         if (div_start) begin
            starts++;
            if (first_start == 0) first_start = n;
         end
         if (n == 30) chk({nm, "/busy_stall"}, stall_o, 64'd1);
         @(posedge clk); #1;
         n++;
      end
      if (!wb_valid_o) begin
         chk({nm, "/timeout"}, wb_valid_o, 64'd1);
         wb_ready_i = 1'b1;
         return;
      end
      chk({nm, "/latency"}, n, exp_fast ? 64'd1 : 64'd69);
      chk({nm, "/starts"}, starts, exp_fast ? 64'd0 : 64'd1);
      if (!exp_fast) chk({nm, "/start_cycle"}, first_start, 64'd1);
      chk({nm, "/data"}, wb_data, exp_d);
      chk({nm, "/rd"}, wb_rd_addr, rd);
      d0 = wb_data;
      for (int k = 0; k < hold; k++) begin
         chk({nm, "/bp_stall"}, stall_o, 64'd1);
         @(posedge clk); #1;
         chk({nm, "/bp_valid"}, wb_valid_o, 64'd1);
         chk({nm, "/bp_data"}, wb_data, d0);
      end
      wb_ready_i = 1'b1;
      #1;
      chk({nm, "/hs_stall"}, stall_o, 64'd0);
      @(posedge clk); #1;
      chk({nm, "/valid_drop"}, wb_valid_o, 64'd0);
   endtask

   // wait out a drained divide; ends in the cycle after div_done
   task automatic drain_wait(input string nm);
      int n, bad;
      n = 0; bad = 0;
      while (n < 120 && !div_done) begin
         if (wb_valid_o || !stall_o) bad++;
         @(posedge clk); #1;
         n++;
      end
      chk({nm, "/done_seen"}, div_done, 64'd1);
      chk({nm, "/no_wb"}, bad, 64'd0);
      @(posedge clk); #1;
      chk({nm, "/idle_valid"}, wb_valid_o, 64'd0);
      chk({nm, "/idle_stall"}, stall_o, 64'd0);
   endtask

   task automatic accept_only(input logic [9:0] op, input logic [63:0] a, input logic [63:0] b);
      ex_valid_i = 1'b1; ex_inst_op_f3 = op; ex_rs1_data = a; ex_rs2_data = b; ex_rd_addr = 5'd9;
      @(posedge clk); #1;
      ex_valid_i = 1'b0;
   endtask

   typedef struct {
      string       nm;
      logic [9:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [4:0]  rd;
      int          hold;
      logic [63:0] exp_d;
      bit          fast;
   } vec_t;

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      vec_t vt[$];
      int   gap, bad, dcyc;
      logic [9:0] ops [8];
      vt.push_back('{"divu_100_7",   T_DIVU,  64'd100, 64'd7, 5'd1, 0, 64'd14, 1'b0});
      vt.push_back('{"remw_neg7_2",  T_REMW,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd2, 0, ONES, 1'b0});
      vt.push_back('{"rem_neg7_2",   T_REM,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd3, 0, ONES, 1'b0});
      vt.push_back('{"div_by0",      T_DIV,   64'd123, 64'd0, 5'd4, 0, ONES, 1'b1});
      vt.push_back('{"remuw_by0",    T_REMUW, 64'h1_8000_0005, 64'h5_0000_0000, 5'd5, 0, 64'hFFFF_FFFF_8000_0005, 1'b1});
      vt.push_back('{"div_ovf",      T_DIV,   MIN64, ONES, 5'd6, 0, MIN64, 1'b1});
      vt.push_back('{"remw_ovf",     T_REMW,  64'h8000_0000, 64'hFFFF_FFFF, 5'd7, 0, 64'd0, 1'b1});
      vt.push_back('{"rem_ovf",      T_REM,   MIN64, ONES, 5'd8, 0, 64'd0, 1'b1});
      vt.push_back('{"divw_ovf",     T_DIVW,  64'h8000_0000, 64'hFFFF_FFFF, 5'd9, 0, 64'hFFFF_FFFF_8000_0000, 1'b1});
      vt.push_back('{"divw_by0",     T_DIVW,  64'd77, 64'h1_0000_0000, 5'd10, 0, ONES, 1'b1});
      vt.push_back('{"remu_by0",     T_REMU,  64'd55, 64'd0, 5'd11, 0, 64'd55, 1'b1});
      vt.push_back('{"divuw_nonovf", T_DIVUW, 64'h8000_0000, 64'hFFFF_FFFF, 5'd12, 0, 64'd0, 1'b0});
      vt.push_back('{"divu_bp",      T_DIVU,  64'd100, 64'd7, 5'd13, 5, 64'd14, 1'b0});
      vt.push_back('{"div_by0_bp",   T_DIV,   64'd1, 64'd0, 5'd14, 3, ONES, 1'b1});

      rst = 1'b1; ex_valid_i = 1'b0; ex_inst_op_f3 = 10'd0; ex_rs1_data = 64'd0;
      ex_rs2_data = 64'd0; ex_rd_addr = 5'd0; flush_i = 1'b0; wb_ready_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst/stall", stall_o, 64'd0);
      chk("rst/valid", wb_valid_o, 64'd0);
      chk("rst/start", div_start, 64'd0);
      chk("rst/data", wb_data, 64'd0);
      chk("rst/dividend", div_dividend, 64'd0);
      rst = 1'b0;
      wb_ready_i = 1'b1;
      @(posedge clk); #1;

      foreach (vt[i]) issue(vt[i].nm, vt[i].op, vt[i].a, vt[i].b, vt[i].rd, vt[i].hold, vt[i].exp_d, vt[i].fast);

      // illegal ops are ignored
      ex_valid_i = 1'b1; ex_inst_op_f3 = 10'b0110011_000; ex_rs2_data = 64'd0;
      #1;
      chk("illegal/stall", stall_o, 64'd0);
      @(posedge clk); #1;
      ex_inst_op_f3 = 10'b0111011_011;
      #1;
      chk("illegal_w/stall", stall_o, 64'd0);
      @(posedge clk); #1;
      ex_valid_i = 1'b0;
      chk("illegal/valid", wb_valid_o, 64'd0);
      chk("illegal/start", div_start, 64'd0);

      // flush in IDLE blocks the accept
      ex_valid_i = 1'b1; ex_inst_op_f3 = T_DIV; ex_rs1_data = 64'd5; ex_rs2_data = 64'd0; flush_i = 1'b1;
      #1;
      chk("flush_idle/stall", stall_o, 64'd0);
      @(posedge clk); #1;
      ex_valid_i = 1'b0; flush_i = 1'b0;
      chk("flush_idle/valid", wb_valid_o, 64'd0);

      // flush in RESP drops the result
      wb_ready_i = 1'b0;
      accept_only(T_DIV, 64'd5, 64'd0);
      chk("flush_resp/valid_before", wb_valid_o, 64'd1);
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0; wb_ready_i = 1'b1;
      chk("flush_resp/valid_after", wb_valid_o, 64'd0);

      // flush in LAUNCH
      accept_only(T_DIVU, 64'd50, 64'd5);
      chk("flush_launch/start", div_start, 64'd1);
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      drain_wait("flush_launch");

      // flush in BUSY at a+20, then a divide right after the drain
      accept_only(T_DIVU, 64'd1000, 64'd3);
      repeat (19) begin @(posedge clk); #1; end
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      drain_wait("flush_busy");
      dcyc = done_cyc;
      issue("after_drain", T_DIVU, 64'd9, 64'd3, 5'd15, 0, 64'd3, 1'b0);
      gap = start_cyc - dcyc;
      chk("after_drain/gap_ok", {63'd0, (gap >= 2)}, 64'd1);

      // reset in the middle of BUSY
      accept_only(T_DIVU, 64'd200, 64'd9);
      repeat (10) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_busy/stall", stall_o, 64'd0);
      chk("rst_busy/valid", wb_valid_o, 64'd0);
      chk("rst_busy/start", div_start, 64'd0);
      chk("rst_busy/data", wb_data, 64'd0);
      chk("rst_busy/rd", wb_rd_addr, 64'd0);
      chk("rst_busy/divisor", div_divisor, 64'd0);
      chk("rst_busy/op", div_op, 64'd0);
      bad = 0;
      repeat (80) begin
         if (wb_valid_o || stall_o || div_done) bad++;
         @(posedge clk); #1;
      end
      chk("rst_busy/quiet", bad, 64'd0);

      // randomized operations against the reference model
      ops = '{T_DIV, T_DIVU, T_REM, T_REMU, T_DIVW, T_DIVUW, T_REMW, T_REMUW};
      for (int i = 0; i < 40; i++) begin
         logic [9:0]  op;
         logic [63:0] a, b;
         bit          w;
         int          mode;
         op = ops[$urandom_range(0, 7)];
         w  = (op[9:3] == 7'b0111011);
         a  = {$urandom, $urandom};
         b  = {$urandom, $urandom} >> $urandom_range(0, 63);
         mode = $urandom_range(0, 5);
         if (mode == 0) b = w ? {$urandom, 32'd0} : 64'd0;
         else if (mode == 1) begin
            a = w ? {$urandom, 32'h8000_0000} : MIN64;
            b = w ? {$urandom, 32'hFFFF_FFFF} : ONES;
         end else if (mode == 2) begin
            a = -64'($urandom_range(1, 1000));
            b = 64'($urandom_range(1, 17));
            if ($urandom_range(0, 1) == 1) b = -b;
         end
         issue($sformatf("rnd%0d", i), op, a, b, 5'($urandom_range(0, 31)),
               $urandom_range(0, 2), ref_result(op, a, b), ref_fast(op, a, b));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
